// File: rtl/clock_pkg.sv
// ============================================================
// clock_pkg : shared types and default limits for the H:M:S engine
// Rev 1.0
// ============================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLK  = 2'd0,
    MODE_TMR  = 2'd1,
    MODE_SW   = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  localparam int c_width    = 6;
  localparam int c_hour_max = 23;
  localparam int c_min_max  = 59;
  localparam int c_sec_max  = 59;

endpackage

`default_nettype wire

// File: rtl/field_counter.sv
// ============================================================
// field_counter : one wrapping W-bit field with load and clamp
// Rev 1.0
// ============================================================
`default_nettype none

module field_counter
  import clock_pkg::*;
#(
  parameter int W   = c_width,
  parameter int MAX = c_sec_max
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_at_max,
  output logic         o_at_zero
);

  localparam logic [W-1:0] c_max = W'(MAX);

  logic [W-1:0] r_count;

  assign o_count   = r_count;
  assign o_at_max  = (r_count == c_max);
  assign o_at_zero = (r_count == '0);

  // Out-of-range values are pulled back to MAX before any counting resumes.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_load_val > c_max) ? c_max : i_load_val;
    end else if (r_count > c_max) begin
      r_count <= c_max;
    end else if (i_inc) begin
      r_count <= o_at_max ? '0 : r_count + W'(1);
    end else if (i_dec) begin
      r_count <= o_at_zero ? c_max : r_count - W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/time_counter_gen.sv
// ============================================================
// time_counter_gen : H:M:S engine for clock, timer and stopwatch
// Rev 1.0
// ============================================================
`default_nettype none

module time_counter_gen
  import clock_pkg::*;
#(
  parameter int W        = c_width,
  parameter int HOUR_MAX = c_hour_max,
  parameter int MIN_MAX  = c_min_max,
  parameter int SEC_MAX  = c_sec_max
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_tick,
  input  logic [1:0]   i_mode,
  input  logic         i_set,
  input  logic [1:0]   i_sel,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_run,
  input  logic         i_reload,
  output logic [W-1:0] o_count_h,
  output logic [W-1:0] o_count_m,
  output logic [W-1:0] o_count_s,
  output logic [1:0]   o_state,
  output logic         o_expired,
  output logic         o_day_carry
);

  state_e       r_state;
  logic         r_expired, r_day_carry, r_up_q, r_down_q, r_set_q;
  logic [1:0]   r_mode_q;
  logic [W-1:0] r_pre_h, r_pre_m, r_pre_s;

  logic [2:0]   w_inc, w_dec, w_max, w_zero;
  logic         w_load, w_ld_zero, w_expire, w_wrap;
  logic         w_up, w_dn, w_set_act, w_mode_chg, w_cnt_mode;
  logic         w_all_max, w_all_zero, w_tmr_last;
  logic [W-1:0] w_ld_h, w_ld_m, w_ld_s;

  assign w_up       = i_up & ~r_up_q & ~(i_down & ~r_down_q);
  assign w_dn       = i_down & ~r_down_q & ~(i_up & ~r_up_q);
  assign w_set_act  = i_set && (i_mode != MODE_HOLD);
  assign w_mode_chg = (i_mode != r_mode_q);
  assign w_cnt_mode = (i_mode == MODE_TMR) || (i_mode == MODE_SW);
  assign w_all_max  = &w_max;
  assign w_all_zero = &w_zero;
  assign w_tmr_last = (o_count_s == W'(1)) && w_zero[1] && w_zero[2];
  assign w_ld_h     = w_ld_zero ? '0 : r_pre_h;
  assign w_ld_m     = w_ld_zero ? '0 : r_pre_m;
  assign w_ld_s     = w_ld_zero ? '0 : r_pre_s;

  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    w_load    = 1'b0;
    w_ld_zero = 1'b0;
    w_expire  = 1'b0;
    w_wrap    = 1'b0;
    if (w_set_act) begin
      case (i_sel)
        SEL_SEC:  begin w_inc[0] = w_up; w_dec[0] = w_dn; end
        SEL_MIN:  begin w_inc[1] = w_up; w_dec[1] = w_dn; end
        SEL_HOUR: begin w_inc[2] = w_up; w_dec[2] = w_dn; end
        default:  ;
      endcase
    end else if (!w_mode_chg) begin
      case (i_mode)
        MODE_CLK: if (i_tick) begin
          w_inc  = {w_max[0] & w_max[1], w_max[0], 1'b1};
          w_wrap = w_all_max;
        end
        MODE_TMR: if (r_state != ST_RUN) begin
          w_load = i_reload;
        end else if (i_run && i_tick && !w_all_zero) begin
          w_dec    = {w_zero[0] & w_zero[1], w_zero[0], 1'b1};
          w_expire = w_tmr_last;
        end
        MODE_SW: if (r_state != ST_RUN) begin
          w_load    = i_reload;
          w_ld_zero = 1'b1;
        end else if (i_run && i_tick) begin
          // Saturated stopwatch holds its value and only reports expiry.
          if (w_all_max) w_expire = 1'b1;
          else           w_inc    = {w_max[0] & w_max[1], w_max[0], 1'b1};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_expired   <= 1'b0;
      r_day_carry <= 1'b0;
      r_up_q      <= 1'b0;
      r_down_q    <= 1'b0;
      r_set_q     <= 1'b0;
      r_mode_q    <= 2'd0;
      r_pre_h     <= '0;
      r_pre_m     <= '0;
      r_pre_s     <= '0;
    end else begin
      r_expired   <= w_expire;
      r_day_carry <= w_wrap;
      r_up_q      <= i_up;
      r_down_q    <= i_down;
      r_set_q     <= i_set;
      r_mode_q    <= i_mode;
      if (r_set_q && !i_set && (i_mode == MODE_TMR)) begin
        r_pre_h <= o_count_h;
        r_pre_m <= o_count_m;
        r_pre_s <= o_count_s;
      end
      if (w_set_act || w_mode_chg || !w_cnt_mode) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (!i_reload && i_run && ((i_mode == MODE_SW) || !w_all_zero))
                     r_state <= ST_RUN;
          ST_RUN:  if (!i_run)        r_state <= ST_IDLE;
                   else if (w_expire) r_state <= ST_DONE;
          ST_DONE: if (i_reload || !i_run) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_state     = r_state;
  assign o_expired   = r_expired;
  assign o_day_carry = r_day_carry;

  field_counter #(.W(W), .MAX(SEC_MAX)) u_sec (
    .i_clk(i_clk), .i_reset(i_reset), .i_inc(w_inc[0]), .i_dec(w_dec[0]),
    .i_load(w_load), .i_load_val(w_ld_s), .o_count(o_count_s),
    .o_at_max(w_max[0]), .o_at_zero(w_zero[0])
  );

  field_counter #(.W(W), .MAX(MIN_MAX)) u_min (
    .i_clk(i_clk), .i_reset(i_reset), .i_inc(w_inc[1]), .i_dec(w_dec[1]),
    .i_load(w_load), .i_load_val(w_ld_m), .o_count(o_count_m),
    .o_at_max(w_max[1]), .o_at_zero(w_zero[1])
  );

  field_counter #(.W(W), .MAX(HOUR_MAX)) u_hour (
    .i_clk(i_clk), .i_reset(i_reset), .i_inc(w_inc[2]), .i_dec(w_dec[2]),
    .i_load(w_load), .i_load_val(w_ld_h), .o_count(o_count_h),
    .o_at_max(w_max[2]), .o_at_zero(w_zero[2])
  );

endmodule

`default_nettype wire

// File: tb/tb_time_counter_gen.sv
// ============================================================
// tb_time_counter_gen : scenario and random checks for 24 h and 12 h builds
// Rev 1.0
// ============================================================
`default_nettype none

module tb_time_counter_gen;

  logic       clk = 1'b0;
  logic       rst_n, tick_i, set_i, up_i, dn_i, run_i, reload_i;
  logic [1:0] mode_i, sel_i;
  logic [5:0] oh[2], om[2], os[2];
  logic [1:0] ost[2];
  logic       oe[2], odc[2];

  int checks = 0;
  int errors = 0;

  // Reference: whole time kept as a seconds total per instance.
  int         hm[2] = '{23, 11};
  int         t[2], pre[2], st[2];
  bit         ex[2], dc[2];
  bit         upq, dnq, setq;
  logic [1:0] modeq;

  always #5 clk = ~clk;

  time_counter_gen #(.W(6), .HOUR_MAX(23)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_tick(tick_i), .i_mode(mode_i), .i_set(set_i),
    .i_sel(sel_i), .i_up(up_i), .i_down(dn_i), .i_run(run_i), .i_reload(reload_i),
    .o_count_h(oh[0]), .o_count_m(om[0]), .o_count_s(os[0]), .o_state(ost[0]),
    .o_expired(oe[0]), .o_day_carry(odc[0])
  );

  time_counter_gen #(.W(6), .HOUR_MAX(11)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_tick(tick_i), .i_mode(mode_i), .i_set(set_i),
    .i_sel(sel_i), .i_up(up_i), .i_down(dn_i), .i_run(run_i), .i_reload(reload_i),
    .o_count_h(oh[1]), .o_count_m(om[1]), .o_count_s(os[1]), .o_state(ost[1]),
    .o_expired(oe[1]), .o_day_carry(odc[1])
  );

  function automatic int adj(int v, int mx, bit u, bit d);
    if (u) return (v == mx) ? 0 : v + 1;
    if (d) return (v == 0) ? mx : v - 1;
    return v;
  endfunction

  function automatic logic [23:0] exp_vec(int k);
    return {6'(t[k] / 3600), 6'((t[k] / 60) % 60), 6'(t[k] % 60), 2'(st[k]), ex[k], dc[k]};
  endfunction

  function automatic logic [23:0] act_vec(int k);
    return {oh[k], om[k], os[k], ost[k], oe[k], odc[k]};
  endfunction

  task automatic model_step();
    bit upe, dne, up, dn, sa, mc;
    upe = up_i && !upq;
    dne = dn_i && !dnq;
    up  = upe && !dne;
    dn  = dne && !upe;
    sa  = set_i && (mode_i != 2'd3);
    mc  = (mode_i != modeq);
    for (int k = 0; k < 2; k++) begin
      int tot, told, h, m, s;
      tot = (hm[k] + 1) * 3600;
      told = t[k];
      ex[k] = 0;
      dc[k] = 0;
      if (!rst_n) begin
        t[k] = 0; pre[k] = 0; st[k] = 0;
      end else begin
        if (sa) begin
          h = t[k] / 3600; m = (t[k] / 60) % 60; s = t[k] % 60;
          case (sel_i)
            2'd0: s = adj(s, 59, up, dn);
            2'd1: m = adj(m, 59, up, dn);
            2'd2: h = adj(h, hm[k], up, dn);
            default: ;
          endcase
          t[k] = h * 3600 + m * 60 + s;
          st[k] = 0;
        end else if (mc || mode_i == 2'd3) begin
          st[k] = 0;
        end else if (mode_i == 2'd0) begin
          st[k] = 0;
          if (tick_i) begin
            if (t[k] == tot - 1) begin t[k] = 0; dc[k] = 1; end
            else t[k]++;
          end
        end else if (st[k] == 1) begin
          if (!run_i) st[k] = 0;
          else if (tick_i) begin
            if (mode_i == 2'd1) begin
              t[k]--;
              if (t[k] == 0) begin ex[k] = 1; st[k] = 2; end
            end else if (t[k] == tot - 1) begin
              ex[k] = 1; st[k] = 2;
            end else t[k]++;
          end
        end else if (reload_i) begin
          t[k] = (mode_i == 2'd1) ? pre[k] : 0;
          st[k] = 0;
        end else if (st[k] == 0) begin
          if (run_i && (mode_i == 2'd2 || t[k] != 0)) st[k] = 1;
        end else if (!run_i) begin
          st[k] = 0;
        end
        if (setq && !set_i && mode_i == 2'd1) pre[k] = told;
      end
    end
    if (!rst_n) begin
      upq = 0; dnq = 0; setq = 0; modeq = 2'd0;
    end else begin
      upq = up_i; dnq = dn_i; setq = set_i; modeq = mode_i;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(input bit u, input bit d);
    up_i = u; dn_i = d;
    cyc();
    up_i = 0; dn_i = 0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 0;
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== 24'h0) begin
        errors++; $display("FAIL reset[%0d] got %h want 000000", k, act_vec(k));
      end
    end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_clock_wrap();
    mode_i = 2'd0; set_i = 1;
    sel_i = 2'd2; press(0, 1);
    sel_i = 2'd1; press(0, 1);
    sel_i = 2'd0; press(0, 1); press(0, 1);
    set_i = 0; cyc();
    checks++;
    if ({oh[0], om[0], os[0]} !== {6'd23, 6'd59, 6'd58} || {oh[1], om[1], os[1]} !== {6'd11, 6'd59, 6'd58}) begin
      errors++; $display("FAIL clk_preset got %0d:%0d:%0d / %0d:%0d:%0d", oh[0], om[0], os[0], oh[1], om[1], os[1]);
    end
    tick_i = 1; cyc(); tick_i = 0;
    checks++;
    if ({oh[0], om[0], os[0], odc[0]} !== {6'd23, 6'd59, 6'd59, 1'b0}) begin
      errors++; $display("FAIL clk_tick1 got %0d:%0d:%0d dc=%0b want 23:59:59 dc=0", oh[0], om[0], os[0], odc[0]);
    end
    tick_i = 1; cyc(); tick_i = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({oh[k], om[k], os[k], odc[k]} !== {18'd0, 1'b1} || act_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL clk_wrap[%0d] got %h want %h", k, act_vec(k), exp_vec(k));
      end
    end
    cyc();
    checks++;
    if (odc[0] !== 1'b0 || odc[1] !== 1'b0) begin
      errors++; $display("FAIL day_carry_width got %0b%0b want 00", odc[0], odc[1]);
    end
  endtask

  task automatic test_set_wrap();
    set_i = 1; sel_i = 2'd1;
    press(0, 1);
    checks++;
    if ({oh[0], om[0], os[0]} !== {6'd0, 6'd59, 6'd0}) begin
      errors++; $display("FAIL set_down got %0d:%0d:%0d want 0:59:0", oh[0], om[0], os[0]);
    end
    press(1, 0);
    checks++;
    if (om[0] !== 6'd0) begin
      errors++; $display("FAIL set_up got %0d want 0", om[0]);
    end
    press(1, 1);
    checks++;
    if (act_vec(0) !== exp_vec(0) || om[0] !== 6'd0) begin
      errors++; $display("FAIL set_both got %h want %h", act_vec(0), exp_vec(0));
    end
    set_i = 0; cyc();
  endtask

  task automatic test_timer_run();
    int n_exp;
    mode_i = 2'd1; cyc();
    set_i = 1;
    sel_i = 2'd1; press(1, 0);
    sel_i = 2'd0; press(1, 0); press(1, 0);
    set_i = 0; cyc();
    run_i = 1; cyc();
    checks++;
    if ({oh[0], om[0], os[0], ost[0]} !== {6'd0, 6'd1, 6'd2, 2'd1}) begin
      errors++; $display("FAIL tmr_start got %h want 0:1:2 RUN", act_vec(0));
    end
    n_exp = 0;
    tick_i = 1;
    for (int i = 0; i < 62; i++) begin
      cyc();
      n_exp += int'(oe[0]);
      checks++;
      if (act_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL tmr_tick%0d got %h want %h", i, act_vec(0), exp_vec(0));
      end
    end
    checks++;
    if ({oh[0], om[0], os[0], ost[0]} !== {18'd0, 2'd2} || n_exp != 1) begin
      errors++; $display("FAIL tmr_done got %h exp_pulses=%0d want DONE, 1", act_vec(0), n_exp);
    end
    repeat (5) cyc();
    tick_i = 0;
    checks++;
    if (act_vec(1) !== {18'd0, 2'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tmr_after_done got %h want 000008", act_vec(1));
    end
  endtask

  task automatic test_pause_reload();
    run_i = 0; cyc();
    reload_i = 1; cyc(); reload_i = 0;
    run_i = 1; cyc();
    tick_i = 1; repeat (32) cyc(); tick_i = 0;
    run_i = 0; cyc();
    checks++;
    if ({oh[0], om[0], os[0], ost[0]} !== {6'd0, 6'd0, 6'd30, 2'd0}) begin
      errors++; $display("FAIL tmr_pause got %h want 0:0:30 IDLE", act_vec(0));
    end
    reload_i = 1; cyc(); reload_i = 0;
    checks++;
    if ({oh[0], om[0], os[0]} !== {6'd0, 6'd1, 6'd2}) begin
      errors++; $display("FAIL tmr_reload got %0d:%0d:%0d want 0:1:2", oh[0], om[0], os[0]);
    end
    run_i = 1; cyc();
    tick_i = 1; cyc();
    reload_i = 1; cyc(); reload_i = 0; tick_i = 0;
    checks++;
    if ({oh[0], om[0], os[0], ost[0]} !== {6'd0, 6'd1, 6'd0, 2'd1} || act_vec(1) !== exp_vec(1)) begin
      errors++; $display("FAIL tmr_reload_run got %h want 0:1:0 RUN", act_vec(0));
    end
  endtask

  task automatic test_reset_midrun();
    tick_i = 1; repeat (20) cyc(); tick_i = 0;
    checks++;
    if ({oh[0], om[0], os[0], ost[0]} !== {6'd0, 6'd0, 6'd40, 2'd1}) begin
      errors++; $display("FAIL pre_reset got %h want 0:0:40 RUN", act_vec(0));
    end
    rst_n = 0; run_i = 0; cyc(); rst_n = 1;
    checks++;
    if (act_vec(0) !== 24'h0 || act_vec(1) !== 24'h0) begin
      errors++; $display("FAIL reset_midrun got %h / %h want 0", act_vec(0), act_vec(1));
    end
    cyc();
    reload_i = 1; cyc(); reload_i = 0;
    checks++;
    if ({oh[0], om[0], os[0]} !== 18'd0 || act_vec(0) !== exp_vec(0)) begin
      errors++; $display("FAIL preset_cleared got %h want 0", act_vec(0));
    end
  endtask

  task automatic test_stopwatch();
    int n_exp;
    mode_i = 2'd2; cyc();
    reload_i = 1; cyc(); reload_i = 0;
    set_i = 1;
    sel_i = 2'd2; press(0, 1);
    sel_i = 2'd1; press(0, 1);
    sel_i = 2'd0; press(0, 1); press(0, 1);
    set_i = 0; cyc();
    run_i = 1; cyc();
    n_exp = 0;
    tick_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_exp += int'(oe[1]);
      checks++;
      if (act_vec(1) !== exp_vec(1) || act_vec(0) !== exp_vec(0)) begin
        errors++; $display("FAIL sw_tick%0d got %h want %h", i, act_vec(1), exp_vec(1));
      end
    end
    tick_i = 0;
    checks++;
    if ({oh[1], om[1], os[1], ost[1]} !== {6'd11, 6'd59, 6'd59, 2'd2} || n_exp != 1) begin
      errors++; $display("FAIL sw_sat got %h exp_pulses=%0d want 11:59:59 DONE, 1", act_vec(1), n_exp);
    end
    run_i = 0; cyc();
    reload_i = 1; cyc(); reload_i = 0;
    checks++;
    if (act_vec(0) !== 24'h0) begin
      errors++; $display("FAIL sw_clear got %h want 0", act_vec(0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      tick_i   = ($urandom % 3) == 0;
      up_i     = ($urandom % 3) == 0;
      dn_i     = ($urandom % 3) == 0;
      sel_i    = 2'($urandom % 4);
      reload_i = ($urandom % 20) == 0;
      rst_n    = ($urandom % 400) != 0;
      if ($urandom % 24 == 0) set_i = ~set_i;
      if ($urandom % 12 == 0) run_i = ~run_i;
      if ($urandom % 80 == 0) mode_i = 2'($urandom % 4);
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL random[%0d] cyc %0d got %h want %h", k, i, act_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; tick_i = 0; set_i = 0; up_i = 0; dn_i = 0;
    run_i = 0; reload_i = 0; mode_i = 2'd0; sel_i = 2'd3;
    t = '{0, 0}; pre = '{0, 0}; st = '{0, 0};
    ex = '{0, 0}; dc = '{0, 0};
    upq = 0; dnq = 0; setq = 0; modeq = 2'd0;
    test_reset();
    test_clock_wrap();
    test_set_wrap();
    test_timer_run();
    test_pause_reload();
    test_reset_midrun();
    test_stopwatch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
